mix_round_ctrl: RTL and testbench
=================================

MIX_ROUND_CTRL -- requirements
Module: mix_round_ctrl

Interface
REQ-001 SHALL have parameter W, default 32: lane word width; only 32 is supported, because the shift amounts 16/17/12 are fixed.
REQ-002 SHALL have parameter RW, default 4: width of the round-count field.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  seed word valid.
REQ-006 in_ready  output  1  block accepts a seed word.
REQ-007 in_data  input  W  seed word; beats carry lanes o0..o7 in order.
REQ-008 cfg_rounds  input  RW  round count R, sampled on the lane-0 seed beat.
REQ-009 out_valid  output  1  result word valid.
REQ-010 out_ready  input  1  consumer accepts a result word.
REQ-011 out_data  output  W  result word.
REQ-012 out_idx  output  3  lane index of out_data.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL hold eight W-bit lane registers o[0..7]; all arithmetic is mod 2^W; shifts are logical.
REQ-015 SHALL implement FSM states IDLE, LOAD, INIT, RA, RX, RS, FIN, OUT, with a 3-bit lane counter ln and an RW-bit round counter rc.
REQ-016 IDLE: in_ready=1; an accepted beat (in_valid&in_ready) writes o[0], latches R=cfg_rounds, sets ln=1, and goes to LOAD.
REQ-017 LOAD: in_ready=1; each accepted beat writes o[ln] and increments ln; the beat with ln=7 goes to INIT with ln=0; cycles without in_valid hold state.
REQ-018 Compute states update exactly one lane per cycle, lane ln; each update reads the current register values, including lanes already updated earlier in the same phase.
REQ-019 INIT: o[ln] = o[ln] + ln.
REQ-020 RA: o[ln] = o[ln] + o[(ln+1)%8] - o[(ln+5)%8].
REQ-021 RX: o[ln] = o[ln] ^ (o[(ln+3)%8] << 16).
REQ-022 RS: o[ln] = o[ln] - (o[(ln+2)%8] >> 17) + (o[(ln+4)%8] >> 12).
REQ-023 FIN: o[ln] = o[ln]*M[ln] + C[ln], with M={2,3,5,7,11,13,17,19} and C={3,5,7,11,13,17,19,23}.
REQ-024 Each compute phase ends when ln wraps 7->0.
REQ-025 Phase order: INIT -> RA -> RX -> RS -> RA ... -> FIN.
REQ-026 At the end of RS, rc increments; if rc+1==R go to FIN, else go to RA.
REQ-027 At the end of INIT, if R==0 go directly to FIN, skipping all rounds; rc clears on entry to INIT.
REQ-028 At the end of FIN go to OUT with ln=0.
REQ-029 OUT: out_valid=1, out_data=o[ln], out_idx=ln.
REQ-030 In OUT, a handshake increments ln; the handshake at ln=7 returns to IDLE.
REQ-031 In OUT, out_data and out_idx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 in_ready SHALL be 0 in INIT, RA, RX, RS, FIN and OUT; in_valid in those states is ignored and no lane is modified.
REQ-033 out_valid SHALL be 0 in every state except OUT.
REQ-034 Latency: the first out_valid is asserted 16+24*R cycles after the edge that accepts the lane-7 seed beat (R=15 gives 376).
REQ-035 A new job SHALL be accepted in the cycle after the final OUT handshake (IDLE, in_ready=1).

Reset
REQ-036 When rst_n=0, asynchronously: state=IDLE, ln=0, rc=0, R=0, o[0..7]=0, in_ready=1, out_valid=0, out_data=0, out_idx=0, busy=0.
REQ-037 Reset asserted mid-job (any state) SHALL abort the job; no result beat follows release.
REQ-038 After rst_n release, the first posedge SHALL accept a seed beat.

Verification
REQ-039 Seed all 0, R=0 -> out_data lanes 0..7 = 3, 8, 17, 32, 57, 82, 121, 156; first out_valid 16 cycles after the last seed beat.
REQ-040 Seed o7=0xFFFFFFFF, others 0, R=0 -> lane 7 = 0x00000089 (wrap check); lanes 0..6 as in REQ-039.
REQ-041 R=1 and R=15 with random seeds -> all 8 lanes match a sequential software model of REQ-019..REQ-023; out_valid latency 40 and 376 cycles respectively.
REQ-042 out_ready held 0 for 5 cycles at lane 3 -> out_idx=3 and out_data stable for those cycles; no lane skipped or duplicated.
REQ-043 in_valid=1 with garbage data throughout compute -> in_ready=0 and results unchanged versus the clean run.
REQ-044 rst_n pulsed low during RX of round 2 -> busy=0 and out_valid=0 immediately; the next job (seed 0, R=0) yields the REQ-039 values.

Source files
------------

// File: rtl/mix_round_ctrl.sv
// Eight-lane word mixer: loads a seed, runs R rounds of add/xor/shift mixing one lane per cycle,
// then streams the eight result lanes out with a valid/ready handshake.
module mix_round_ctrl #(
    parameter int W  = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [RW-1:0] cfg_rounds,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [2:0]    out_idx,
    output logic          busy
);
    localparam int NL = 8;
    localparam logic [RW-1:0] ONE_R = 1;

    typedef enum logic [2:0] {IDLE, LOAD, INIT, RA, RX, RS, FIN, OUT} state_t;

    state_t        state, state_n;
    logic [2:0]    ln, ln_n, wi;
    logic [RW-1:0] rc, rc_n, rr, rr_n, rc_inc;
    logic [W-1:0]  o [NL];
    logic          we;
    logic [W-1:0]  nv, nv_cmp, mul_k, add_k;
    logic [2:0]    i1, i2, i3, i4, i5;

    assign i1     = ln + 3'd1;
    assign i2     = ln + 3'd2;
    assign i3     = ln + 3'd3;
    assign i4     = ln + 3'd4;
    assign i5     = ln + 3'd5;
    assign rc_inc = rc + ONE_R;

    always_comb begin
        mul_k = W'(2);
        add_k = W'(3);
        case (ln)
            3'd0: begin mul_k = W'(2);  add_k = W'(3);  end
            3'd1: begin mul_k = W'(3);  add_k = W'(5);  end
            3'd2: begin mul_k = W'(5);  add_k = W'(7);  end
            3'd3: begin mul_k = W'(7);  add_k = W'(11); end
            3'd4: begin mul_k = W'(11); add_k = W'(13); end
            3'd5: begin mul_k = W'(13); add_k = W'(17); end
            3'd6: begin mul_k = W'(17); add_k = W'(19); end
            default: begin mul_k = W'(19); add_k = W'(23); end
        endcase
    end

    // Single shared datapath; reads live registers so earlier lanes of a phase feed later ones
    always_comb begin
        nv_cmp = o[ln];
        case (state)
            INIT:    nv_cmp = o[ln] + {{(W-3){1'b0}}, ln};
            RA:      nv_cmp = o[ln] + o[i1] - o[i5];
            RX:      nv_cmp = o[ln] ^ (o[i3] << 16);
            RS:      nv_cmp = o[ln] - (o[i2] >> 17) + (o[i4] >> 12);
            FIN:     nv_cmp = o[ln] * mul_k + add_k;
            default: nv_cmp = o[ln];
        endcase
    end

    always_comb begin
        state_n   = state;
        ln_n      = ln;
        rc_n      = rc;
        rr_n      = rr;
        we        = 1'b0;
        wi        = ln;
        nv        = in_data;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    we      = 1'b1;
                    wi      = 3'd0;
                    rr_n    = cfg_rounds;
                    ln_n    = 3'd1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    we   = 1'b1;
                    ln_n = ln + 3'd1;
                    if (ln == 3'd7) begin
                        rc_n    = '0;
                        state_n = INIT;
                    end
                end
            end
            INIT, RA, RX, RS, FIN: begin
                we   = 1'b1;
                nv   = nv_cmp;
                ln_n = ln + 3'd1;
                if (ln == 3'd7) begin
                    case (state)
                        INIT: state_n = (rr == '0) ? FIN : RA;
                        RA:   state_n = RX;
                        RX:   state_n = RS;
                        RS: begin
                            rc_n    = rc_inc;
                            state_n = (rc_inc == rr) ? FIN : RA;
                        end
                        default: state_n = OUT;
                    endcase
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ln_n = ln + 3'd1;
                    if (ln == 3'd7) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ln    <= '0;
            rc    <= '0;
            rr    <= '0;
            for (int i = 0; i < NL; i++) o[i] <= '0;
        end else begin
            state <= state_n;
            ln    <= ln_n;
            rc    <= rc_n;
            rr    <= rr_n;
            for (int i = 0; i < NL; i++)
                if (we && wi == 3'(i)) o[i] <= nv;
        end
    end

    assign out_data = (state == OUT) ? o[ln] : '0;
    assign out_idx  = ln;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_mix_round_ctrl.sv
// Randomized bench for mix_round_ctrl: a sequential software model of the mixing rounds feeds
// an expected-beat queue that one negedge monitor checks against every valid output cycle.
module tb_mix_round_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
    logic [31:0] in_data = '0, out_data;
    logic [3:0]  cfg_rounds = '0;
    logic [2:0]  out_idx;

    typedef logic [31:0] lanes_t [8];
    typedef struct packed { logic [2:0] idx; logic [31:0] data; } beat_t;

    int     checks = 0, errors = 0;
    beat_t  exp_q[$];
    lanes_t got;
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;
    logic [2:0]  pi = '0;

    mix_round_ctrl #(.W(32), .RW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_rounds(cfg_rounds), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic lanes_t model(input lanes_t s, input int r);
        lanes_t o = s;
        int M [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
        int C [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
        for (int i = 0; i < 8; i++) o[i] = o[i] + 32'(i);
        for (int k = 0; k < r; k++) begin
            for (int i = 0; i < 8; i++) o[i] = o[i] + o[(i+1)%8] - o[(i+5)%8];
            for (int i = 0; i < 8; i++) o[i] = o[i] ^ (o[(i+3)%8] << 16);
            for (int i = 0; i < 8; i++) o[i] = o[i] - (o[(i+2)%8] >> 17) + (o[(i+4)%8] >> 12);
        end
        for (int i = 0; i < 8; i++) o[i] = o[i] * 32'(M[i]) + 32'(C[i]);
        return o;
    endfunction

    // Output monitor: every valid beat must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
                else begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
                    if (out_ready) begin
                        got[out_idx] = out_data;
                        void'(exp_q.pop_front());
                    end
                end
                chk("in_ready_during_out", 32'(in_ready), 32'd0);
                if (pv && !pr) begin
                    chk("hold_data", out_data, pd);
                    chk("hold_idx", 32'(out_idx), 32'(pi));
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx;
        end
    end

    task automatic load(input lanes_t s, input int r);
        for (int b = 0; b < 8; b++) begin
            repeat ($urandom_range(0, 1)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            chk("in_ready_load", 32'(in_ready), 32'd1);
            in_valid   = 1'b1;
            in_data    = s[b];
            cfg_rounds = (b == 0) ? 4'(r) : 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_job(input lanes_t s, input int r, input bit garbage, input int mode);
        lanes_t e = model(s, r);
        int n = 0, hold = 0;
        load(s, r);
        for (int i = 0; i < 8; i++) exp_q.push_back('{idx: 3'(i), data: e[i]});
        while (!out_valid && n < 600) begin
            chk("in_ready_compute", 32'(in_ready), 32'd0);
            in_valid   = garbage;
            in_data    = $urandom;
            cfg_rounds = 4'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'(16 + 24 * r));
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (out_valid && out_idx == 3'd3 && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end else out_ready = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes_t z, s, m;
        lanes_t lit0 = '{32'd3, 32'd8, 32'd17, 32'd32, 32'd57, 32'd82, 32'd121, 32'd156};
        lanes_t lit1 = '{32'd3, 32'd8, 32'd17, 32'd32, 32'd57, 32'd82, 32'd121, 32'h89};
        for (int i = 0; i < 8; i++) z[i] = '0;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #5 rst_n = 1'b1;

        m = model(z, 0);
        for (int i = 0; i < 8; i++) chk("model_pin_zero", m[i], lit0[i]);
        s = z; s[7] = 32'hFFFF_FFFF;
        m = model(s, 0);
        chk("model_pin_wrap", m[7], 32'h89);

        send_job(z, 0, 1'b0, 0);
        for (int i = 0; i < 8; i++) chk("dut_zero_seed", got[i], lit0[i]);
        send_job(s, 0, 1'b0, 1);
        for (int i = 0; i < 8; i++) chk("dut_wrap_seed", got[i], lit1[i]);

        for (int i = 0; i < 8; i++) s[i] = $urandom;
        send_job(s, 1, 1'b0, 1);
        for (int i = 0; i < 8; i++) s[i] = $urandom;
        send_job(s, 15, 1'b1, 0);
        for (int i = 0; i < 8; i++) s[i] = $urandom;
        send_job(s, 2, 1'b1, 2);
        repeat (5) begin
            for (int i = 0; i < 8; i++) s[i] = $urandom;
            send_job(s, $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // abort mid-job during RX of the second round
        for (int i = 0; i < 8; i++) s[i] = $urandom;
        load(s, 3);
        repeat (44) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_data", out_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        send_job(z, 0, 1'b0, 0);
        for (int i = 0; i < 8; i++) chk("dut_after_abort", got[i], lit0[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
